// File: rtl/rv_pkg.sv
// Shared RV32I register-file constants and types used by the register file,
// its bus interface and the read-port mux.
package rv_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = $clog2(NREG);

  localparam logic [REG_AW-1:0] REG_ZERO = REG_AW'(0);

  typedef logic [XLEN-1:0]   xlen_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

  function automatic logic is_zero_reg(input reg_addr_t addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/rf_regfile_if.sv
// Register-file bus: decode-side read addresses, writeback-side write
// request, and the two combinational read-data returns.
interface rf_regfile_if #(
  parameter int XLEN = rv_pkg::XLEN,
  parameter int NREG = rv_pkg::NREG
);
  localparam int AW = $clog2(NREG);

  logic            we;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic [AW-1:0]   rd;
  logic [XLEN-1:0] wd;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  modport master (
    output we, rs1, rs2, rd, wd,
    input  rd1, rd2
  );

  modport slave (
    input  we, rs1, rs2, rd, wd,
    output rd1, rd2
  );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: selects a register by address and forces
// zero for x0 regardless of what sits in slot 0 of the flattened array.
module rf_read_port #(
  parameter  int XLEN = rv_pkg::XLEN,
  parameter  int NREG = rv_pkg::NREG,
  localparam int AW   = $clog2(NREG)
) (
  input  logic [AW-1:0]              addr,
  input  logic [NREG-1:0][XLEN-1:0]  regs,
  output logic [XLEN-1:0]            data
);

  assign data = (addr == AW'(0)) ? '0 : regs[addr];

endmodule

// File: rtl/rf_regfile.sv
// RV32I integer register file: x1..x31 in flops with async active-low reset,
// one synchronous write port, two combinational read ports, x0 reads zero.
module rf_regfile #(
  parameter  int XLEN = rv_pkg::XLEN,
  parameter  int NREG = rv_pkg::NREG,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  rf_regfile_if.slave   bus
);

  // Slot 0 is a constant so the read muxes can index the full address space.
  logic [NREG-1:0][XLEN-1:0] regs_all;

  assign regs_all[0] = '0;

  for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
    logic            wr_sel;
    logic [XLEN-1:0] x_d;
    logic [XLEN-1:0] x_q;

    assign wr_sel = bus.we && (bus.rd == AW'(gi));

    always_comb begin
      x_d = x_q;
      if (wr_sel) begin
        x_d = bus.wd;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        x_q <= '0;
      end else begin
        x_q <= x_d;
      end
    end

    assign regs_all[gi] = x_q;
  end

  rf_read_port #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_read_port_1 (
    .addr (bus.rs1),
    .regs (regs_all),
    .data (bus.rd1)
  );

  rf_read_port #(
    .XLEN (XLEN),
    .NREG (NREG)
  ) u_read_port_2 (
    .addr (bus.rs2),
    .regs (regs_all),
    .data (bus.rd2)
  );

endmodule

// File: tb/tb_rf_regfile.sv
// Self-checking bench for rf_regfile: architectural register model plus
// directed vectors with hand-computed literal expectations.
module tb_rf_regfile;

  logic clk;
  logic rst_n;

  rf_regfile_if bus ();

  rf_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural view: 32 registers, x0 never written.
  logic [31:0] model [0:31];
  int          checks   = 0;
  int          failures = 0;
  logic        cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Called just after a rising edge; applies inputs, waits one edge, retires the write.
  task automatic step(input logic we_i, input logic [4:0] rd_i, input logic [31:0] wd_i,
                      input logic [4:0] rs1_i, input logic [4:0] rs2_i);
    bus.we  = we_i;
    bus.rd  = rd_i;
    bus.wd  = wd_i;
    bus.rs1 = rs1_i;
    bus.rs2 = rs2_i;
    @(posedge clk);
    if (rst_n && we_i && rd_i != 5'd0) model[rd_i] = wd_i;
    #1;
    $display("step we=%0d rd=%0d wd=%h rs1=%0d rs2=%0d -> rd1=%h rd2=%h",
             we_i, rd_i, wd_i, rs1_i, rs2_i, bus.rd1, bus.rd2);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_rd1", bus.rd1, model[bus.rs1]);
      check("model_rd2", bus.rd2, model[bus.rs2]);
    end
  end

  initial begin
    model_clear();
    rst_n   = 1'b0;
    bus.we  = 1'b0;
    bus.rd  = 5'd0;
    bus.wd  = 32'h0;
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd6;
    #12;
    check("reset_rd1_x0", bus.rd1, 32'h0);
    check("reset_rd2_x6", bus.rd2, 32'h0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Write, then overwrite x1.
    step(1'b1, 5'd1, 32'hDEADBEEF, 5'd1, 5'd0);
    check("x1_write", bus.rd1, 32'hDEADBEEF);
    step(1'b1, 5'd1, 32'h11111111, 5'd1, 5'd1);
    check("x1_overwrite_p1", bus.rd1, 32'h11111111);
    check("x1_overwrite_p2", bus.rd2, 32'h11111111);

    // Ignored writes: x0 target and we=0.
    step(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    check("x0_write_ignored", bus.rd1, 32'h0);
    step(1'b0, 5'd6, 32'h99999999, 5'd6, 5'd6);
    check("we0_x6_p1", bus.rd1, 32'h0);
    check("we0_x6_p2", bus.rd2, 32'h0);

    // Back-to-back writes and dual read.
    step(1'b1, 5'd2, 32'h12345678, 5'd1, 5'd2);
    step(1'b1, 5'd3, 32'hCAFEBABE, 5'd1, 5'd2);
    check("dual_rd1", bus.rd1, 32'h11111111);
    check("dual_rd2", bus.rd2, 32'h12345678);
    step(1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    check("x3_b2b", bus.rd2, 32'hCAFEBABE);

    // Pattern sweep on every register, reading on both ports.
    for (int i = 1; i < 32; i++) step(1'b1, 5'(i), 32'h10000000 | i, 5'(i - 1), 5'(32 - i));
    for (int i = 1; i < 32; i++) begin
      step(1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i));
      check("sweep_rd1", bus.rd1, 32'h10000000 | i);
      check("sweep_rd2", bus.rd2, 32'h10000000 | (32 - i));
    end
    for (int i = 1; i < 32; i++) step(1'b1, 5'(i), 32'h0, 5'(i), 5'(31 - i));
    for (int i = 0; i < 32; i++) step(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
    check("cleared_x31", bus.rd1, 32'h0);

    // Combinational address change, no clock edge in between.
    step(1'b1, 5'd3, 32'h33333333, 5'd0, 5'd0);
    step(1'b1, 5'd4, 32'h44444444, 5'd0, 5'd0);
    step(1'b1, 5'd7, 32'h07070707, 5'd0, 5'd0);
    bus.we  = 1'b0;
    bus.rs1 = 5'd3;
    #1;
    check("comb_rs1_3", bus.rd1, 32'h33333333);
    bus.rs1 = 5'd4;
    #1;
    check("comb_rs1_4", bus.rd1, 32'h44444444);

    // No bypass: old value until the edge, new value after.
    bus.we  = 1'b1;
    bus.rd  = 5'd7;
    bus.wd  = 32'h77777777;
    bus.rs1 = 5'd7;
    bus.rs2 = 5'd4;
    #1;
    check("nobypass_old", bus.rd1, 32'h07070707);
    step(1'b1, 5'd7, 32'h77777777, 5'd7, 5'd4);
    check("nobypass_new", bus.rd1, 32'h77777777);

    // Mid-test reset, held across a write edge: reset wins.
    step(1'b1, 5'd5, 32'h55555555, 5'd5, 5'd7);
    check("x5_before_reset", bus.rd1, 32'h55555555);
    rst_n = 1'b0;
    model_clear();
    #1;
    check("reset_async_x5", bus.rd1, 32'h0);
    check("reset_async_x7", bus.rd2, 32'h0);
    step(1'b1, 5'd5, 32'hA5A5A5A5, 5'd5, 5'd3);
    check("reset_wins_write", bus.rd1, 32'h0);
    rst_n = 1'b1;
    step(1'b0, 5'd0, 32'h0, 5'd5, 5'd1);
    check("after_reset_x5", bus.rd1, 32'h0);
    check("after_reset_x1", bus.rd2, 32'h0);
    step(1'b1, 5'd9, 32'h0BADF00D, 5'd9, 5'd9);
    check("post_reset_write", bus.rd2, 32'h0BADF00D);

    cmp_en = 1'b0;
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
